moltiplicatore_seq: RTL and testbench

MOLTIPLICATORE_SEQ -- requirements
Module: moltiplicatore_seq

---
 rtl/molt_pkg.sv | 17 +
 rtl/sommatore.sv | 15 +
 rtl/moltiplicatore_seq.sv | 118 +++++++++++
 tb/tb_moltiplicatore_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/molt_pkg.sv
// Shared constants and types for the sequential 16x16 shift-and-add multiplier.
package molt_pkg;

   localparam int WIDTH = 16;
   localparam int CNT_W = 5;
   localparam int P_W   = 2 * WIDTH;

   // Count value seen during the last of the WIDTH CALC cycles.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

endpackage

// File: rtl/sommatore.sv
// Combinational W-bit ripple adder with carry in and carry out.
module sommatore #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         r_in,
   output logic [W-1:0] s,
   output logic         r_out
);

   // Widen every operand by one bit so the carry out lands in the top bit.
   assign {r_out, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, r_in};

endmodule

// File: rtl/moltiplicatore_seq.sv
// Sequential unsigned 16x16 multiplier, one partial product per clock.
// Operands are latched on start; the 32-bit product appears after 16 CALC
// cycles, flagged by a one-cycle done pulse.
// Optional feature: define MOLT_OVF_EN to add the registered ovf output
// (high when the product does not fit in 16 bits).
module moltiplicatore_seq
   import molt_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [P_W-1:0]   p,
   output logic             busy,
   output logic             done
`ifdef MOLT_OVF_EN
   ,
   output logic             ovf
`endif
);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] sum;
   logic             c;
   logic [WIDTH-1:0] acc_shift;
   logic [WIDTH-1:0] q_shift;
   logic             last_step;

   // Add the multiplicand only when the current multiplier bit is set.
   assign addend = q[0] ? mcand : '0;

   sommatore #(
      .W(WIDTH)
   ) u_add (
      .a    (acc_hi),
      .b    (addend),
      .r_in (1'b0),
      .s    (sum),
      .r_out(c)
   );

   // {c,sum,q} shifted right by one: the carry is kept as the new MSB.
   assign acc_shift = {c, sum[WIDTH-1:1]};
   assign q_shift   = {sum[0], q[WIDTH-1:1]};
   assign last_step = (state == CALC) && (count == LAST_CNT);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses <= so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and status outputs.
   always_comb begin
      // NOTE: defaults first so no path leaves an output unassigned (no latch).
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: if (start) state_next = CALC;
         CALC: begin
            busy = 1'b1;
            if (count == LAST_CNT) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, shift-and-add datapath and product register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         mcand  <= '0;
         q      <= '0;
         acc_hi <= '0;
         p      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= a;
                  q      <= b;
                  acc_hi <= '0;
                  count  <= '0;
               end
            end
            CALC: begin
               acc_hi <= acc_shift;
               q      <= q_shift;
               count  <= count + CNT_W'(1);
               if (last_step) p <= {acc_shift, q_shift};
            end
            default: ;
         endcase
      end
   end

`ifdef MOLT_OVF_EN
   // Overflow flag, written together with the product and held with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            ovf <= 1'b0;
      else if (last_step) ovf <= |acc_shift;
   end
`endif

endmodule

// File: tb/tb_moltiplicatore_seq.sv
// Self-checking bench for moltiplicatore_seq: directed vector table, operand
// corruption during CALC, reset abort, randomized products and back-to-back
// starts. Define MOLT_OVF_EN to also check the ovf output.
module tb_moltiplicatore_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic [31:0] p;
   logic        busy;
   logic        done;
`ifdef MOLT_OVF_EN
   logic        ovf;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp_p;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   moltiplicatore_seq dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .p    (p),
      .busy (busy),
      .done (done)
`ifdef MOLT_OVF_EN
      ,
      .ovf  (ovf)
`endif
   );

   // Reference: the exact unsigned product.
   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
      logic [31:0] xx;
      logic [31:0] yy;
      xx = {16'h0000, x};
      yy = {16'h0000, y};
      return xx * yy;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Present operands with start high ahead of the next rising edge.
   task automatic launch(input logic [15:0] av, input logic [15:0] bv);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
   endtask

   // Follow one operation from its accepting edge for 20 cycles.
   // Operands are scrambled throughout; with perturb, start is also re-pulsed during CALC.
   task automatic observe(input logic [31:0] exp_p, input bit perturb, input string tag);
      int          busy_cnt;
      int          done_cnt;
      int          done_at;
      logic [31:0] p_at_done;
      busy_cnt  = 0;
      done_cnt  = 0;
      done_at   = -1;
      p_at_done = '0;
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         a     = 16'($urandom);
         b     = 16'($urandom);
         start = (perturb && k >= 3 && k <= 10) ? 1'b1 : 1'b0;
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at   = k;
               p_at_done = p;
            end
         end
      end
      check({tag, "_busy_cycles"}, busy_cnt, 16);
      check({tag, "_done_cycle"}, done_at, 17);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_p_at_done"}, p_at_done, exp_p);
      check({tag, "_p_held"}, p, exp_p);
`ifdef MOLT_OVF_EN
      check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, |exp_p[31:16]});
`endif
   endtask

   initial begin
      logic [15:0] ah[0:79];
      logic [15:0] bh[0:79];
      logic [15:0] ra;
      logic [15:0] rb;
      int          dn;
      int          rst_done;

      vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
      vecs[2] = '{16'h1234, 16'h0010, 32'h00012340};
      vecs[3] = '{16'h0000, 16'hABCD, 32'h00000000};
      vecs[4] = '{16'h8000, 16'h0002, 32'h00010000};
      vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};

      // Reset state.
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      check("reset_p", p, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'h0);
      check("reset_done", {31'b0, done}, 32'h0);
`ifdef MOLT_OVF_EN
      check("reset_ovf", {31'b0, ovf}, 32'h0);
`endif

      // Release reset and request on the very first edge afterwards.
      rst   = 1'b0;
      a     = vecs[0].a;
      b     = vecs[0].b;
      start = 1'b1;
      observe(vecs[0].exp_p, 1'b0, "first_after_rst");

      // Directed vector table.
      for (int i = 1; i < 6; i++) begin
         launch(vecs[i].a, vecs[i].b);
         observe(vecs[i].exp_p, 1'b0, $sformatf("vec%0d", i));
      end

      // start re-pulsed with new operands during CALC is ignored.
      launch(16'h0002, 16'h0003);
      a = 16'h0002;
      observe(32'h00000006, 1'b1, "ignore_start");

      // Reset in the middle of CALC aborts the operation.
      launch(16'h0007, 16'h0009);
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         start = 1'b0;
         a     = 16'($urandom);
         b     = 16'($urandom);
      end
      check("abort_busy_before", {31'b0, busy}, 32'h1);
      rst = 1'b1;
      #1;
      check("abort_busy", {31'b0, busy}, 32'h0);
      check("abort_p", p, 32'h0);
      rst_done = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done === 1'b1) rst_done++;
      end
      check("abort_no_done", rst_done, 0);
      rst   = 1'b0;
      a     = 16'h00C8;
      b     = 16'h0123;
      start = 1'b1;
      observe(ref_mul(16'h00C8, 16'h0123), 1'b0, "after_abort");

      // Randomized products against the reference.
      for (int i = 0; i < 8; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         launch(ra, rb);
         observe(ref_mul(ra, rb), 1'b0, $sformatf("rand%0d", i));
      end

      // start held high: a product every 18 cycles, each from the operands
      // present at its accepting edge (edges 0, 18, 36, 54 of this window).
      dn = 0;
      @(negedge clk);
      for (int k = 0; k <= 71; k++) begin
         if (k > 0 && done === 1'b1) begin
            if (dn < 4) begin
               check($sformatf("b2b%0d_pos", dn), k, 17 + 18 * dn);
               check($sformatf("b2b%0d_p", dn), p, ref_mul(ah[18 * dn], bh[18 * dn]));
            end
            dn++;
         end
         ah[k] = 16'($urandom);
         bh[k] = 16'($urandom);
         a     = ah[k];
         b     = bh[k];
         start = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      check("b2b_count", dn, 4);
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
